mem_responder: RTL and testbench
================================

# mem_responder

Data-memory responder for the single-cycle CPU's data port. It answers `memwrite`/address/`writedata` requests with `readdata` and holds a word-addressed RAM plus a small memory-mapped I/O window: an output FIFO drained by an external valid/ready consumer, a free-running cycle counter and a sticky error flag. It sits between the CPU's data port and the top-level testbench or board wrapper.

## Interface
- `DEPTH`, 64: RAM size in 32-bit words; power of two, ≥ 4.
- `FIFO_DEPTH`, 4: output FIFO entries; power of two, 2..16.
- `IO_BASE`, 32'hFFFF_FF00: base byte address of the I/O window.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `memwrite`  in  1  store strobe from the CPU; qualifies `addr` and `writedata`.
- `addr`  in  32  byte address (CPU ALU result).
- `writedata`  in  32  store data.
- `readdata`  out  32  load data; combinational from `addr`.
- `out_data`  out  32  FIFO head word.
- `out_valid`  out  1  FIFO is not empty.
- `out_ready`  in  1  consumer accepts the head when `out_valid` is high.
- `err`  out  1  sticky access-error flag.

## Operation
- RAM region covers `addr < DEPTH*4`. The word index is `addr[$clog2(DEPTH)+1:2]`.
- I/O window, as offsets from `IO_BASE`:
  - +0x0 OUT: a write pushes `writedata` into the FIFO; a read returns 0.
  - +0x4 STATUS: read-only. Value is {24'b0, `err`, full, empty, count[4:0]}.
  - +0x8 CYCLE: a read returns the counter. A write loads `writedata`, and the load takes priority over the increment.
  - +0xC ERRCLR: a write clears `err`; a read returns 0.
- Reads of any other address return 0 and have no side effect.
- A store sets `err` and has no other effect when:
  - `addr[1:0] != 0` (misaligned); or
  - the address is unmapped (outside RAM and the four I/O words); or
  - it targets OUT while the FIFO is full and no pop happens in the same cycle. The word is dropped.
- A misaligned read returns 0 and does not set `err`. The CPU may read speculatively.
- FIFO rules:
  - Push = valid store to OUT. Pop = `out_valid && out_ready`.
  - Push and pop in the same cycle while full: both are accepted and count is unchanged.
  - Push while empty: the word appears on `out_data` with `out_valid=1` on the next cycle. There is no bypass.
  - Pointers wrap modulo `FIFO_DEPTH`. Count ranges 0..`FIFO_DEPTH`.
- CYCLE increments by 1 every cycle outside reset and wraps from 32'hFFFF_FFFF to 0.
- An ERRCLR write in the same cycle as a new error leaves `err`=1, because set beats clear.

## Timing
- `readdata` is combinational, valid in the same cycle as `addr`, with no wait states. A load in cycle N returns RAM contents as of the end of cycle N-1.
- Store latency is one edge: a store in cycle N is readable in cycle N+1. A load to the same address in cycle N returns the old value.
- `out_data` and `out_valid` are registered and change only on the rising edge.
- Reset values, applied whenever `reset` is high, including mid-stream:
  - FIFO flushed: `out_valid`=0, `out_data`=0, count=0.
  - CYCLE=0 and `err`=0.
  - A store during reset is ignored.
  - `readdata` remains combinational.
- RAM is not cleared by reset and its contents survive it. Power-up RAM contents are X.
- The first cycle after reset is deasserted reads CYCLE=0; the next cycle reads 1.

## Structure
- Package `mem_map_pkg` holds:
  - the OUT/STATUS/CYCLE/ERRCLR offset localparams and the default `IO_BASE`;
  - the STATUS bit positions (ERR=7, FULL=6, EMPTY=5, COUNT=4:0);
  - the address-decode enum {REG_RAM, REG_OUT, REG_STATUS, REG_CYCLE, REG_ERRCLR, REG_NONE}.
- Sub-module `sync_fifo #(WIDTH, DEPTH)` provides push/pop/full/empty/count with synchronous active-high reset. The responder instantiates it once.
- RAM, the address decoder, CYCLE and `err` live in `mem_responder`.

## Test plan
- RAM round trip: store 0xDEADBEEF to 0x10, load 0x10 the next cycle → 0xDEADBEEF. A load in the store cycle returns the prior value.
- FIFO handshake: `out_ready`=0, store 1,2,3,4 to OUT → STATUS=0x44. A fifth store sets `err`, reads STATUS=0xC4, and the word is dropped. Then `out_ready`=1 drains 1,2,3,4 on consecutive cycles and ends with `out_valid`=0.
- Full push+pop: FIFO full with `out_ready`=1 and a store of 5 in the same cycle → no `err`, count stays 4, and the drained order ends with 5.
- CYCLE: write 0xFFFF_FFFE, then read on the next two cycles → 0xFFFF_FFFE, 0xFFFF_FFFF, then 0 (wrap).
- Errors: store to 0x13 (misaligned) and store to 0x8000 (unmapped) → `err`=1 and RAM is unchanged. A write to ERRCLR clears it. A simultaneous ERRCLR and bad store leaves `err`=1.
- Reset mid-stream: with 3 words queued, CYCLE≈100 and `err`=1, assert `reset` for one cycle → `out_valid`=0, STATUS=0x20, CYCLE reads 0, and RAM word 0x10 still reads 0xDEADBEEF.

Source files
------------

// File: rtl/mem_map_pkg.sv
// rtl/mem_map_pkg.sv - I/O window offsets, STATUS layout and address-decode regions
package mem_map_pkg;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_FF00;

    localparam logic [31:0] OFS_OUT    = 32'h0;
    localparam logic [31:0] OFS_STATUS = 32'h4;
    localparam logic [31:0] OFS_CYCLE  = 32'h8;
    localparam logic [31:0] OFS_ERRCLR = 32'hC;

    localparam int STAT_ERR       = 7;
    localparam int STAT_FULL      = 6;
    localparam int STAT_EMPTY     = 5;
    localparam int STAT_COUNT_MSB = 4;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_OUT,
        REG_STATUS,
        REG_CYCLE,
        REG_ERRCLR,
        REG_NONE
    } region_e;

endpackage

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - CPU data port plus output-stream handshake
interface mem_responder_if;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        err;

    modport slave (
        input  memwrite, addr, writedata, out_ready,
        output readdata, out_data, out_valid, err
    );

    modport master (
        output memwrite, addr, writedata, out_ready,
        input  readdata, out_data, out_valid, err
    );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with registered storage and head word
module sync_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - data-memory responder: word RAM plus OUT/STATUS/CYCLE/ERRCLR window
module mem_responder
    import mem_map_pkg::*;
#(
    parameter int          DEPTH      = 64,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] IO_BASE    = IO_BASE_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);

    localparam int          AW        = $clog2(DEPTH);
    localparam int          CW        = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

    logic [31:0]   r_ram [DEPTH];
    logic [31:0]   r_cycle;
    logic          r_err;

    region_e       w_region;
    logic          w_aligned;
    logic [AW-1:0] w_idx;
    logic          w_wr_ok;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic          w_err_set;
    logic          w_err_clr;
    logic [31:0]   w_status;

    always_comb begin
        w_region = REG_NONE;
        if (bus.addr < RAM_BYTES) begin
            w_region = REG_RAM;
        end else if (bus.addr == IO_BASE + OFS_OUT) begin
            w_region = REG_OUT;
        end else if (bus.addr == IO_BASE + OFS_STATUS) begin
            w_region = REG_STATUS;
        end else if (bus.addr == IO_BASE + OFS_CYCLE) begin
            w_region = REG_CYCLE;
        end else if (bus.addr == IO_BASE + OFS_ERRCLR) begin
            w_region = REG_ERRCLR;
        end
    end

    assign w_aligned = (bus.addr[1:0] == 2'b00);
    assign w_idx     = bus.addr[AW+1:2];
    assign w_wr_ok   = bus.memwrite && !reset && w_aligned;

    assign w_pop  = !w_empty && bus.out_ready;
    assign w_push = w_wr_ok && (w_region == REG_OUT) && (!w_full || w_pop);

    // Misaligned, unmapped or overflowing stores are all dropped and flagged.
    assign w_err_set = bus.memwrite && !reset &&
                       (!w_aligned || (w_region == REG_NONE) ||
                        ((w_region == REG_OUT) && w_full && !w_pop));
    assign w_err_clr = w_wr_ok && (w_region == REG_ERRCLR);

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (bus.writedata),
        .i_pop   (w_pop),
        .o_data  (bus.out_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign bus.out_valid = !w_empty;
    assign bus.err       = r_err;

    // RAM has no reset so its contents survive a mid-stream reset.
    always_ff @(posedge clk) begin
        if (w_wr_ok && (w_region == REG_RAM)) begin
            r_ram[w_idx] <= bus.writedata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_wr_ok && (w_region == REG_CYCLE)) begin
                r_cycle <= bus.writedata;
            end else begin
                r_cycle <= r_cycle + 32'd1;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (w_err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    always_comb begin
        w_status                   = '0;
        w_status[STAT_ERR]         = r_err;
        w_status[STAT_FULL]        = w_full;
        w_status[STAT_EMPTY]       = w_empty;
        w_status[STAT_COUNT_MSB:0] = 5'(w_count);
    end

    always_comb begin
        bus.readdata = '0;
        if (w_aligned) begin
            case (w_region)
                REG_RAM:    bus.readdata = r_ram[w_idx];
                REG_STATUS: bus.readdata = w_status;
                REG_CYCLE:  bus.readdata = r_cycle;
                default:    bus.readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder
module tb_mem_responder;

    localparam logic [31:0] IOB = 32'hFFFF_FF00;
    localparam int          FD  = 4;

    logic clk = 1'b0;
    logic reset;

    mem_responder_if bus();

    mem_responder #(
        .DEPTH      (64),
        .FIFO_DEPTH (FD),
        .IO_BASE    (IOB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] sb_q[$];
    logic        pend;
    logic [31:0] pend_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic apply(input logic we, input logic [31:0] a, input logic [31:0] wd);
        bus.memwrite  = we;
        bus.addr      = a;
        bus.writedata = wd;
        pend      = !reset && we && (a == IOB) &&
                    (sb_q.size() < FD || (sb_q.size() > 0 && bus.out_ready));
        pend_data = wd;
        #1;
    endtask

    task automatic tick();
        logic [31:0] exp_word;
        check("out_valid", {31'b0, bus.out_valid}, {31'b0, sb_q.size() != 0});
        if (bus.out_valid && bus.out_ready && sb_q.size() > 0) begin
            exp_word = sb_q.pop_front();
            check("out_data", bus.out_data, exp_word);
        end
        if (pend) sb_q.push_back(pend_data);
        pend = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.memwrite = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] exp, input string tag);
        apply(1'b0, a, 32'h0);
        check(tag, bus.readdata, exp);
        tick();
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] wd);
        apply(1'b1, a, wd);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        pend          = 1'b0;
        pend_data     = '0;
        bus.memwrite  = 1'b0;
        bus.addr      = '0;
        bus.writedata = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);

        apply(1'b0, IOB + 32'h4, 32'h0);
        check("rst_status", bus.readdata, 32'h20);
        check("rst_valid", {31'b0, bus.out_valid}, 32'h0);
        check("rst_data", bus.out_data, 32'h0);
        check("rst_err", {31'b0, bus.err}, 32'h0);

        reset = 1'b0;
        apply(1'b0, IOB + 32'h8, 32'h0);
        check("cycle_first", bus.readdata, 32'h0);
        tick();
        load(IOB + 32'h8, 32'h1, "cycle_second");

        store(32'h10, 32'h1111_1111);
        apply(1'b1, 32'h10, 32'hDEAD_BEEF);
        check("ram_same_cycle_old", bus.readdata, 32'h1111_1111);
        tick();
        load(32'h10, 32'hDEAD_BEEF, "ram_roundtrip");

        for (int i = 1; i <= 4; i++) store(IOB, 32'(i));
        load(IOB + 32'h4, 32'h44, "status_full");
        store(IOB, 32'h5);
        check("err_overflow", {31'b0, bus.err}, 32'h1);
        load(IOB + 32'h4, 32'hC4, "status_full_err");
        bus.out_ready = 1'b1;
        repeat (5) tick();
        load(IOB + 32'h4, 32'hA0, "status_drained");
        store(IOB + 32'hC, 32'h0);
        check("errclr", {31'b0, bus.err}, 32'h0);

        bus.out_ready = 1'b0;
        for (int i = 10; i <= 13; i++) store(IOB, 32'(i));
        bus.out_ready = 1'b1;
        store(IOB, 32'h5);
        check("pushpop_no_err", {31'b0, bus.err}, 32'h0);
        bus.out_ready = 1'b0;
        load(IOB + 32'h4, 32'h44, "pushpop_count");
        bus.out_ready = 1'b1;
        repeat (5) tick();

        store(IOB + 32'h8, 32'hFFFF_FFFE);
        load(IOB + 32'h8, 32'hFFFF_FFFE, "cycle_load");
        load(IOB + 32'h8, 32'hFFFF_FFFF, "cycle_inc");
        load(IOB + 32'h8, 32'h0, "cycle_wrap");

        store(32'h13, 32'h0000_0BAD);
        check("err_misaligned", {31'b0, bus.err}, 32'h1);
        load(32'h13, 32'h0, "misaligned_read");
        load(32'h10, 32'hDEAD_BEEF, "ram_after_misaligned");
        store(IOB + 32'hC, 32'h0);
        check("errclr2", {31'b0, bus.err}, 32'h0);
        store(32'h8000, 32'h0000_0BAD);
        check("err_unmapped", {31'b0, bus.err}, 32'h1);
        load(32'h10, 32'hDEAD_BEEF, "ram_after_unmapped");
        store(IOB + 32'hD, 32'h0);
        check("errclr_misaligned_keeps", {31'b0, bus.err}, 32'h1);
        store(IOB + 32'hC, 32'h0);
        store(IOB + 32'h4, 32'hFF);
        check("status_write_no_err", {31'b0, bus.err}, 32'h0);
        load(IOB + 32'h4, 32'h20, "status_readonly");

        bus.out_ready = 1'b0;
        store(IOB, 32'hA1);
        store(IOB, 32'hA2);
        store(IOB, 32'hA3);
        store(32'h8000, 32'h0);
        repeat (90) tick();
        load(IOB + 32'h4, 32'h83, "pre_reset_status");
        reset = 1'b1;
        apply(1'b1, 32'h10, 32'h0);
        tick();
        sb_q.delete();
        reset = 1'b0;
        #1;
        check("mid_rst_valid", {31'b0, bus.out_valid}, 32'h0);
        check("mid_rst_data", bus.out_data, 32'h0);
        check("mid_rst_err", {31'b0, bus.err}, 32'h0);
        load(IOB + 32'h8, 32'h0, "mid_rst_cycle");
        load(IOB + 32'h4, 32'h20, "mid_rst_status");
        load(32'h10, 32'hDEAD_BEEF, "ram_survives_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
